// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Holds the state enum, opcode constants, datapath select encodings and the registered control word.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_HALT
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alucontrol_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  // How the ALU decoder interprets funct3/funct7b5 in a given state.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_e;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Control word registered alongside the state; is_fetch/is_beq/pc_jump
  // qualify the few outputs that also depend on same-cycle inputs.
  typedef struct packed {
    logic        mem_req;
    logic        memwrite;
    logic        adrsrc;
    logic        regwrite;
    logic        is_fetch;
    logic        is_beq;
    logic        pc_jump;
    logic [1:0]  memtoreg;
    logic [1:0]  alusrca;
    logic [1:0]  alusrcb;
    immsrc_e     immsrc;
    alucontrol_e alucontrol;
    logic        alu_illegal;
    logic        halted;
  } ctrl_t;

  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: aluop/funct3/funct7b5 -> alucontrol, plus an
// illegal flag for funct3 values the datapath does not implement.
module alu_decoder
  import multicycle_pkg::*;
(
  input  aluop_e      aluop,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output alucontrol_e alucontrol,
  output logic        illegal
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    unique case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        unique case (funct3)
          3'b000:  alucontrol = (funct7b5 && aluop == ALUOP_RTYPE) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM driving the datapath selects and a unified memory port.
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int PERF_W      = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] memtoreg,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       halted
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_instret
`endif
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e        state, next_state;
  ctrl_t         ctrl, nxt;
  logic [TW-1:0] tcount;
  logic          mem_wait, timed_out;

  aluop_e        aluop;
  alucontrol_e   dec_alucontrol;
  logic          dec_illegal;

  assign mem_wait  = ctrl.mem_req & ~mem_ready;
  assign timed_out = (MEM_TIMEOUT != 0) && mem_wait && (tcount == TLAST);

  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH: begin
        if (timed_out)                      next_state = S_HALT;
        else if (ctrl.mem_req && mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_HALT;
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (timed_out)                      next_state = S_HALT;
        else if (ctrl.mem_req && mem_ready) next_state = S_MEMWB;
      end
      S_MEMWR: begin
        if (timed_out)                      next_state = S_HALT;
        else if (ctrl.mem_req && mem_ready) next_state = S_FETCH;
      end
      S_EXECR, S_EXECI: next_state = ctrl.alu_illegal ? S_HALT : S_ALUWB;
      S_JAL:            next_state = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: next_state = S_FETCH;
      S_HALT:           next_state = S_HALT;
      default:          next_state = S_HALT;
    endcase
  end

  // The decoder sees the state being entered, so its result lands in the output register.
  always_comb begin
    unique case (next_state)
      S_EXECR: aluop = ALUOP_RTYPE;
      S_EXECI: aluop = ALUOP_ITYPE;
      S_BEQ:   aluop = ALUOP_SUB;
      default: aluop = ALUOP_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop     (aluop),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .alucontrol(dec_alucontrol),
    .illegal   (dec_illegal)
  );

  always_comb begin
    nxt             = '0;
    nxt.alucontrol  = dec_alucontrol;
    nxt.alu_illegal = dec_illegal;
    unique case (next_state)
      S_FETCH: begin
        nxt.mem_req  = 1'b1;
        nxt.is_fetch = 1'b1;
        nxt.alusrca  = SRCA_PC;
        nxt.alusrcb  = SRCB_FOUR;
        nxt.memtoreg = RES_ALURESULT;
      end
      S_DECODE: begin
        nxt.alusrca = SRCA_OLDPC;
        nxt.alusrcb = SRCB_IMM;
        nxt.immsrc  = IMM_B;
      end
      S_MEMADR: begin
        nxt.alusrca = SRCA_RS1;
        nxt.alusrcb = SRCB_IMM;
        nxt.immsrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMRD: begin
        nxt.mem_req = 1'b1;
        nxt.adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        nxt.memtoreg = RES_MEMDATA;
        nxt.regwrite = 1'b1;
      end
      S_MEMWR: begin
        nxt.mem_req  = 1'b1;
        nxt.memwrite = 1'b1;
        nxt.adrsrc   = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        nxt.alusrca = SRCA_RS1;
        nxt.alusrcb = (next_state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        nxt.immsrc  = IMM_I;
      end
      S_ALUWB: begin
        nxt.memtoreg = RES_ALUOUT;
        nxt.regwrite = 1'b1;
      end
      S_BEQ: begin
        nxt.alusrca  = SRCA_RS1;
        nxt.alusrcb  = SRCB_RS2;
        nxt.memtoreg = RES_ALUOUT;
        nxt.is_beq   = 1'b1;
      end
      S_JAL: begin
        nxt.alusrca  = SRCA_OLDPC;
        nxt.alusrcb  = SRCB_FOUR;
        nxt.memtoreg = RES_ALUOUT;
        nxt.pc_jump  = 1'b1;
      end
      S_HALT:  nxt.halted = 1'b1;
      default: nxt.halted = 1'b1;
    endcase
  end

  // Reset leaves the control word at zero while sitting in FETCH: the request
  // only rises after the first clock, and an in-flight access drops at once.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      ctrl   <= '0;
      tcount <= '0;
    end else begin
      state <= next_state;
      ctrl  <= nxt;
      if (is_wait_state(next_state) && (next_state != state)) tcount <= '0;
      else if (mem_wait)                                      tcount <= tcount + 1'b1;
    end
  end

  assign mem_req    = ctrl.mem_req;
  assign memwrite   = ctrl.memwrite;
  assign adrsrc     = ctrl.adrsrc;
  assign regwrite   = ctrl.regwrite;
  assign memtoreg   = ctrl.memtoreg;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign immsrc     = ctrl.immsrc;
  assign alucontrol = ctrl.alucontrol;
  assign halted     = ctrl.halted;
  assign irwrite    = ctrl.is_fetch & ctrl.mem_req & mem_ready;
  assign pcwrite    = (ctrl.is_fetch & ctrl.mem_req & mem_ready) | (ctrl.is_beq & zero) | ctrl.pc_jump;

`ifdef MC_CTRL_PERF_EN
  logic retire;
  assign retire = (next_state == S_FETCH) &&
                  ((state == S_MEMWB) || (state == S_MEMWR) || (state == S_ALUWB) || (state == S_BEQ));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycles  <= '0;
      perf_instret <= '0;
    end else if (state != S_HALT) begin
      perf_cycles <= perf_cycles + 1'b1;
      if (retire) perf_instret <= perf_instret + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level model expands each
// instruction into per-cycle expected control words, compared every cycle.
module tb_multicycle_ctrl;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;

  typedef struct packed {
    logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
    logic [1:0] memtoreg, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    logic       halted;
  } ctl_t;

  typedef struct {
    logic        ready;
    logic        zero;
    ctl_t        exp;
    logic [63:0] tag;
  } cyc_t;

  logic clk, reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic funct7b5, zero, mem_ready;
  logic mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
  logic [1:0] memtoreg, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic halted;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_instret;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
    .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc),
    .alucontrol(alucontrol), .halted(halted)
`ifdef MC_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_instret(perf_instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   data_req_cycles, wr_cycles, halt_cycles;
  cyc_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic ctl_t dut_word();
    ctl_t c;
    c = {mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
         memtoreg, alusrca, alusrcb, immsrc, alucontrol, halted};
    return c;
  endfunction

  // Expected ALU operation straight from the funct3 table.
  function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input logic rdy, input logic z, input ctl_t e, input logic [63:0] tag);
    cyc_t c;
    c.ready = rdy; c.zero = z; c.exp = e; c.tag = tag;
    q.push_back(c);
  endtask

  function automatic ctl_t w_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_req = 1'b1; c.alusrcb = 2'b10; c.memtoreg = 2'b10;
    c.irwrite = rdy;  c.pcwrite = rdy;
    return c;
  endfunction

  function automatic ctl_t w_halt();
    ctl_t c = '0;
    c.halted = 1'b1;
    return c;
  endfunction

  function automatic ctl_t w_wb(input logic [1:0] src);
    ctl_t c = '0;
    c.regwrite = 1'b1; c.memtoreg = src;
    return c;
  endfunction

  // Expand one instruction into its expected cycles (fetch stalls / data stalls as given).
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input int fstall, input int mstall, input logic z);
    ctl_t c;
    opcode = op; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < fstall; i++) push(1'b0, 1'b1, w_fetch(1'b0), "FETCH");
    push(1'b1, 1'b1, w_fetch(1'b1), "FETCH");
    c = '0; c.alusrca = 2'b01; c.alusrcb = 2'b01; c.immsrc = 2'b10;
    push(1'b1, 1'b1, c, "DECODE");
    case (op)
      T_LW, T_SW: begin
        c = '0; c.alusrca = 2'b10; c.alusrcb = 2'b01; c.immsrc = (op == T_SW) ? 2'b01 : 2'b00;
        push(1'b1, 1'b1, c, "MEMADR");
        c = '0; c.mem_req = 1'b1; c.adrsrc = 1'b1; c.memwrite = (op == T_SW);
        for (int i = 0; i < mstall; i++) push(1'b0, 1'b1, c, "MEMACC");
        push(1'b1, 1'b1, c, "MEMACC");
        if (op == T_LW) push(1'b1, 1'b1, w_wb(2'b01), "MEMWB");
      end
      T_R, T_I: begin
        c = '0; c.alusrca = 2'b10; c.alusrcb = (op == T_I) ? 2'b01 : 2'b00;
        c.alucontrol = alu_exp(f3, f7, op == T_R);
        push(1'b1, 1'b1, c, "EXEC");
        push(1'b1, 1'b1, w_wb(2'b00), "ALUWB");
      end
      T_BEQ: begin
        c = '0; c.alusrca = 2'b10; c.alucontrol = 3'b001; c.pcwrite = z;
        push(1'b1, z, c, "BEQ");
      end
      T_JAL: begin
        c = '0; c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcwrite = 1'b1;
        push(1'b1, 1'b1, c, "JAL");
        push(1'b1, 1'b1, w_wb(2'b00), "ALUWB");
      end
      default: for (int i = 0; i < 20; i++) push(1'b1, 1'b1, w_halt(), "HALT");
    endcase
  endtask

  // Single compare process: drive inputs on the falling edge, check 1ns later.
  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.ready;
      zero      = c.zero;
      #1;
      cyc++;
      check($sformatf("c%0d_%0s", cyc, c.tag), 32'(dut_word()), 32'(c.exp));
      if (mem_req && adrsrc) data_req_cycles++;
      if (regwrite)          wr_cycles++;
      if (halted)            halt_cycles++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", 32'(dut_word()), 32'd0);
    reset = 1'b1;
    #1;
    check("post_release_outs", 32'(dut_word()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    do_reset();

    check("pin_alu_sub",  32'(alu_exp(3'b000, 1'b1, 1'b1)), 32'h1);
    check("pin_alu_addi", 32'(alu_exp(3'b000, 1'b1, 1'b0)), 32'h0);
    check("pin_alu_slt",  32'(alu_exp(3'b010, 1'b0, 1'b1)), 32'h5);

    // R-type sub straight out of reset, then the other R/I encodings.
    instr(T_R, 3'b000, 1'b1, 0, 0, 1'b0); run_q();
    instr(T_R, 3'b000, 1'b0, 0, 0, 1'b0); run_q();
    instr(T_R, 3'b110, 1'b0, 1, 0, 1'b0); run_q();
    instr(T_R, 3'b111, 1'b0, 0, 0, 1'b0); run_q();
    instr(T_R, 3'b010, 1'b0, 0, 0, 1'b0); run_q();
    instr(T_I, 3'b000, 1'b1, 0, 0, 1'b0); run_q();
    instr(T_I, 3'b110, 1'b0, 0, 0, 1'b0); run_q();

    // lw with three data-wait cycles: one below the timeout limit.
    data_req_cycles = 0;
    instr(T_LW, 3'b010, 1'b0, 0, 3, 1'b0); run_q();
    check("lw_req_cycles", 32'(data_req_cycles), 32'd4);

    data_req_cycles = 0; wr_cycles = 0;
    instr(T_SW, 3'b010, 1'b0, 3, 0, 1'b0); run_q();
    check("sw_req_cycles", 32'(data_req_cycles), 32'd1);
    check("sw_no_regwrite", 32'(wr_cycles), 32'd0);

    instr(T_BEQ, 3'b000, 1'b0, 0, 0, 1'b1); run_q();
    instr(T_BEQ, 3'b000, 1'b0, 0, 0, 1'b0); run_q();
    instr(T_JAL, 3'b000, 1'b0, 0, 0, 1'b0); run_q();
    instr(T_SW, 3'b010, 1'b0, 0, 2, 1'b0); run_q();

    // Reset asserted while a load is waiting on memory.
    opcode = T_LW; funct3 = 3'b010;
    instr(T_LW, 3'b010, 1'b0, 0, 0, 1'b0);
    q = q[0:2];
    run_q();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("abort_pre_req", 32'({mem_req, adrsrc}), 32'h3);
    #2 reset = 1'b0;
    #1;
    check("abort_now", 32'(dut_word()), 32'd0);
    do_reset();

    // Illegal opcode halts and ignores mem_ready until reset.
    halt_cycles = 0;
    instr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0); run_q();
    check("halt_cycles", 32'(halt_cycles), 32'd20);
    do_reset();
    instr(T_R, 3'b111, 1'b0, 0, 0, 1'b0); run_q();

    // Fetch never answered: four waiting cycles, then HALT with the request dropped.
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, w_fetch(1'b0), "TO_FETCH");
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, w_halt(), "TO_HALT");
    run_q();
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("timeout_sticky", 32'({halted, mem_req, irwrite}), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
